// File: rtl/tl_master_port_if.sv
// TileLink-UL A/D channel bundle (64-bit data, 8-bit source/sink) shared by
// initiators and targets; the master modport drives A and d_ready.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic [7:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
               a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied,
               d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
               a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied,
               d_data, d_corrupt
    );
endinterface

// File: rtl/tl_master_port.sv
// Single-outstanding TileLink initiator: one core request -> one A beat -> one extended result.
// Optional response watchdog enabled by defining TL_TIMEOUT_EN.
module tl_master_port #(
    parameter int unsigned SOURCE_ID      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [2:0]  i_req_param,
    input  logic [2:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [63:0] o_rsp_data,
    output logic        o_rsp_error,
    tilelink.master     bus
);

    localparam logic [2:0] TL_PUT_F      = 3'd0;
    localparam logic [2:0] TL_PUT_P      = 3'd1;
    localparam logic [2:0] TL_ARITH_DATA = 3'd2;
    localparam logic [2:0] TL_LOGIC_DATA = 3'd3;
    localparam logic [2:0] TL_GET        = 3'd4;
    localparam logic [7:0] SRC_ID        = SOURCE_ID[7:0];

    typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        w_accept;
    logic        w_d_take;
    logic        w_d_match;
    logic        w_timeout;
    logic        w_timeout_fire;
    logic [2:0]  w_opcode;
    logic [2:0]  w_param;
    logic [7:0]  w_mask;

    logic [2:0]  r_a_opcode;
    logic [2:0]  r_a_param;
    logic [2:0]  r_a_size;
    logic [63:0] r_a_address;
    logic [7:0]  r_a_mask;
    logic [63:0] r_a_data;
    logic        r_is_store;
    logic        r_signed;
    logic        r_d_ready;
    logic [63:0] r_rsp_data;

    // Truncate to the access width, then sign- or zero-extend back to 64 bits.
    function automatic logic [63:0] f_extend(input logic [63:0] d, input logic [1:0] sz,
                                             input logic sgn);
        logic [63:0] res;
        res = d;
        unique case (sz)
            2'd0: res = sgn ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
            2'd1: res = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
            2'd2: res = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
            2'd3: res = d;
            default: res = d;
        endcase
        return res;
    endfunction

    always_comb begin
        w_opcode = TL_GET;
        w_param  = 3'd0;
        unique case (i_req_op)
            2'd0: w_opcode = TL_GET;
            2'd1: w_opcode = (i_req_size == 3'd3) ? TL_PUT_F : TL_PUT_P;
            2'd2: begin
                w_opcode = TL_ARITH_DATA;
                w_param  = i_req_param;
            end
            2'd3: begin
                w_opcode = TL_LOGIC_DATA;
                w_param  = i_req_param;
            end
            default: w_opcode = TL_GET;
        endcase
    end

    always_comb begin
        w_mask = 8'h01;
        unique case (i_req_size[1:0])
            2'd0: w_mask = 8'h01;
            2'd1: w_mask = 8'h03;
            2'd2: w_mask = 8'h0F;
            2'd3: w_mask = 8'hFF;
            default: w_mask = 8'h01;
        endcase
    end

    assign w_d_match = bus.d_valid && (bus.d_source == SRC_ID);

    always_comb begin
        w_state_d      = r_state;
        w_accept       = 1'b0;
        w_d_take       = 1'b0;
        w_timeout_fire = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (bus.a_ready) w_state_d = StWait;
            end
            StWait: begin
                if (w_d_match) begin
                    w_d_take  = 1'b1;
                    w_state_d = StRsp;
                end else if (w_timeout) begin
                    w_timeout_fire = 1'b1;
                    w_state_d      = StRsp;
                end
            end
            StRsp: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_a_opcode  <= 3'd0;
            r_a_param   <= 3'd0;
            r_a_size    <= 3'd0;
            r_a_address <= 64'd0;
            r_a_mask    <= 8'd0;
            r_a_data    <= 64'd0;
            r_is_store  <= 1'b0;
            r_signed    <= 1'b0;
            r_d_ready   <= 1'b0;
            r_rsp_data  <= 64'd0;
        end else begin
            r_state   <= w_state_d;
            r_d_ready <= 1'b1;
            if (w_accept) begin
                r_a_opcode  <= w_opcode;
                r_a_param   <= w_param;
                r_a_size    <= i_req_size;
                r_a_address <= i_req_addr;
                r_a_mask    <= w_mask;
                r_a_data    <= i_req_wdata;
                r_is_store  <= (i_req_op == 2'd1);
                r_signed    <= i_req_signed;
                // Cleared here so a timed-out request reports zero data.
                r_rsp_data  <= 64'd0;
            end
            if (w_d_take) begin
                r_rsp_data <= r_is_store ? 64'd0 : f_extend(bus.d_data, r_a_size[1:0], r_signed);
            end
        end
    end

`ifdef TL_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_inc;
    logic        r_rsp_error;

    assign w_wait_cnt_inc = r_wait_cnt + 16'd1;
    assign w_timeout      = ({16'd0, w_wait_cnt_inc} == TIMEOUT_CYCLES);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt  <= 16'd0;
            r_rsp_error <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == StWait) ? w_wait_cnt_inc : 16'd0;
            if (w_accept) begin
                r_rsp_error <= 1'b0;
            end else if (w_timeout_fire) begin
                r_rsp_error <= 1'b1;
            end
        end
    end

    assign o_rsp_error = r_rsp_error;
`else
    logic [31:0] w_unused_timeout;
    logic        w_unused_fire;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_unused_fire    = w_timeout_fire;
    assign o_rsp_error      = 1'b0;
`endif

    logic w_unused_d;
    assign w_unused_d = ^{bus.d_opcode, bus.d_param, bus.d_size, bus.d_sink, bus.d_denied,
                          bus.d_corrupt};

    assign o_req_ready   = (r_state == StIdle);
    assign o_rsp_valid   = (r_state == StRsp);
    assign o_rsp_data    = r_rsp_data;

    assign bus.a_valid   = (r_state == StReq);
    assign bus.a_opcode  = r_a_opcode;
    assign bus.a_param   = r_a_param;
    assign bus.a_size    = r_a_size;
    assign bus.a_source  = SRC_ID;
    assign bus.a_address = r_a_address;
    assign bus.a_mask    = r_a_mask;
    assign bus.a_data    = r_a_data;
    assign bus.a_corrupt = 1'b0;
    assign bus.d_ready   = r_d_ready;

endmodule

// File: tb/tb_tl_master_port.sv
// Self-checking bench for tl_master_port: vector table through a memory-backed slave,
// plus hand sequences for backpressure, source filtering, reset abort and timeout.
module tb_tl_master_port;

    localparam logic [7:0] SRC           = 8'd3;
    localparam logic [2:0] TL_PUT_F      = 3'd0;
    localparam logic [2:0] TL_PUT_P      = 3'd1;
    localparam logic [2:0] TL_ARITH_DATA = 3'd2;
    localparam logic [2:0] TL_LOGIC_DATA = 3'd3;
    localparam logic [2:0] TL_GET        = 3'd4;
    localparam logic [2:0] TL_PARAM_ADD  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [2:0]  req_param = 3'd0;
    logic [2:0]  req_size = 3'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_error;

    always #5 clk = ~clk;

    tilelink bus ();

    tl_master_port #(
        .SOURCE_ID      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_param  (req_param),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_error  (rsp_error),
        .bus          (bus)
    );

    // Slave side: automatic zero-wait responder or manually driven D channel.
    logic        tb_a_ready = 1'b1;
    logic        slave_auto = 1'b1;
    logic        auto_valid = 1'b0;
    logic [7:0]  auto_src = 8'd0;
    logic [63:0] auto_data = 64'd0;
    logic        man_valid = 1'b0;
    logic [7:0]  man_src = 8'd0;
    logic [63:0] man_data = 64'd0;

    assign bus.a_ready   = tb_a_ready;
    assign bus.d_valid   = slave_auto ? auto_valid : man_valid;
    assign bus.d_source  = slave_auto ? auto_src : man_src;
    assign bus.d_data    = slave_auto ? auto_data : man_data;
    assign bus.d_opcode  = 3'd1;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = 3'd3;
    assign bus.d_sink    = 8'd0;
    assign bus.d_denied  = 1'b0;
    assign bus.d_corrupt = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Memory model and captured A beat
    logic [63:0] mem [logic [63:0]];
    logic [2:0]  cap_opcode, cap_param, cap_size;
    logic [7:0]  cap_mask, cap_source;
    logic [63:0] cap_addr, cap_data;
    int          n_a_hs = 0;

    initial begin : slave
        logic        hs;
        logic [2:0]  c_op, c_par, c_sz;
        logic [7:0]  c_mask, c_src;
        logic [63:0] c_addr, c_data, old, bm;
        forever begin
            @(posedge clk);
            hs     = bus.a_valid && bus.a_ready && rst_n;
            c_op   = bus.a_opcode;
            c_par  = bus.a_param;
            c_sz   = bus.a_size;
            c_mask = bus.a_mask;
            c_src  = bus.a_source;
            c_addr = bus.a_address;
            c_data = bus.a_data;
            #1;
            if (hs) begin
                n_a_hs++;
                cap_opcode = c_op;
                cap_param  = c_par;
                cap_size   = c_sz;
                cap_mask   = c_mask;
                cap_source = c_src;
                cap_addr   = c_addr;
                cap_data   = c_data;
                old = mem.exists(c_addr) ? mem[c_addr] : 64'd0;
                auto_data = old;
                if (c_op == TL_PUT_F || c_op == TL_PUT_P) begin
                    for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{c_mask[i]}};
                    mem[c_addr] = (old & ~bm) | (c_data & bm);
                    auto_data = 64'hA5A5_A5A5_A5A5_A5A5;
                end else if (c_op == TL_ARITH_DATA && c_par == TL_PARAM_ADD) begin
                    mem[c_addr] = old + c_data;
                end
                auto_src   = c_src;
                auto_valid = 1'b1;
            end else begin
                auto_valid = 1'b0;
            end
        end
    end

    // Scoreboard of expected responses
    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   rsp_cnt = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got rsp_data 0x%0h, required no response",
                             rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic push_exp(input logic [63:0] d, input logic err);
        exp_t e;
        e.data = d;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Drive one request; returns one #1 after the accepting edge (cycle 1).
    task automatic issue(input logic [1:0] op, input logic [2:0] par, input logic [2:0] sz,
                         input logic sgn, input logic [63:0] addr, input logic [63:0] wd);
        @(posedge clk);
        #1;
        chk("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_param  = par;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  param;
        logic [2:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  exp_opc;
        logic [2:0]  exp_param;
        logic [7:0]  exp_mask;
        logic [63:0] exp_rsp;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int lat;
        int c0;
        int h0;

        vecs[0] = '{2'd0, 3'd5, 3'd0, 1'b1, 64'h1000_0005, 64'd0,
                    TL_GET, 3'd0, 8'h01, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{2'd1, 3'd6, 3'd2, 1'b0, 64'h2000, 64'hDEAD_BEEF,
                    TL_PUT_P, 3'd0, 8'h0F, 64'd0};
        vecs[2] = '{2'd0, 3'd0, 3'd2, 1'b0, 64'h2000, 64'd0,
                    TL_GET, 3'd0, 8'h0F, 64'h0000_0000_DEAD_BEEF};
        vecs[3] = '{2'd0, 3'd0, 3'd2, 1'b1, 64'h2000, 64'd0,
                    TL_GET, 3'd0, 8'h0F, 64'hFFFF_FFFF_DEAD_BEEF};
        vecs[4] = '{2'd0, 3'd0, 3'd1, 1'b1, 64'h2000, 64'd0,
                    TL_GET, 3'd0, 8'h03, 64'hFFFF_FFFF_FFFF_BEEF};
        vecs[5] = '{2'd1, 3'd0, 3'd3, 1'b0, 64'h3000, 64'd10,
                    TL_PUT_F, 3'd0, 8'hFF, 64'd0};
        vecs[6] = '{2'd2, TL_PARAM_ADD, 3'd3, 1'b0, 64'h3000, 64'd5,
                    TL_ARITH_DATA, TL_PARAM_ADD, 8'hFF, 64'd10};
        vecs[7] = '{2'd0, 3'd0, 3'd3, 1'b1, 64'h3000, 64'd0,
                    TL_GET, 3'd0, 8'hFF, 64'd15};
        vecs[8] = '{2'd3, 3'd2, 3'd0, 1'b0, 64'h1000_0005, 64'h0F,
                    TL_LOGIC_DATA, 3'd2, 8'h01, 64'h80};

        mem[64'h1000_0005] = 64'h80;

        // Reset state
        #12;
        chk("rst_a_valid", {63'd0, bus.a_valid}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_d_ready", {63'd0, bus.d_ready}, 64'd0);
        chk("rst_a_address", bus.a_address, 64'd0);
        chk("rst_a_opcode", {61'd0, bus.a_opcode}, {61'd0, 3'd0});
        chk("rst_a_mask", {56'd0, bus.a_mask}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("d_ready_after_rst", {63'd0, bus.d_ready}, 64'd1);

        // Table-driven transactions against the zero-wait slave
        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].exp_rsp, 1'b0);
            issue(vecs[i].op, vecs[i].param, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                  vecs[i].wdata);
            wait_rsp(lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'd3);
            chk($sformatf("a_opcode[%0d]", i), {61'd0, cap_opcode}, {61'd0, vecs[i].exp_opc});
            chk($sformatf("a_param[%0d]", i), {61'd0, cap_param}, {61'd0, vecs[i].exp_param});
            chk($sformatf("a_mask[%0d]", i), {56'd0, cap_mask}, {56'd0, vecs[i].exp_mask});
            chk($sformatf("a_size[%0d]", i), {61'd0, cap_size}, {61'd0, vecs[i].size});
            chk($sformatf("a_address[%0d]", i), cap_addr, vecs[i].addr);
            chk($sformatf("a_data[%0d]", i), cap_data, vecs[i].wdata);
            chk($sformatf("a_source[%0d]", i), {56'd0, cap_source}, {56'd0, SRC});
        end

        // Backpressure: a_ready low for three cycles
        c0 = rsp_cnt;
        tb_a_ready = 1'b0;
        push_exp(64'd15, 1'b0);
        issue(2'd0, 3'd0, 3'd3, 1'b0, 64'h3000, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_a_valid", {63'd0, bus.a_valid}, 64'd1);
            chk("bp_a_address", bus.a_address, 64'h3000);
            chk("bp_a_opcode", {61'd0, bus.a_opcode}, {61'd0, TL_GET});
            chk("bp_a_mask", {56'd0, bus.a_mask}, 64'hFF);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        tb_a_ready = 1'b1;
        wait_rsp(lat);
        chk("bp_latency", 64'(lat), 64'd3);
        repeat (4) @(negedge clk);
        chk("bp_rsp_count", 64'(rsp_cnt - c0), 64'd1);

        // Source filtering; D during the A handshake cycle and in IDLE is dropped
        c0 = rsp_cnt;
        slave_auto = 1'b0;
        push_exp(64'h1234, 1'b0);
        issue(2'd0, 3'd0, 3'd3, 1'b0, 64'h4000, 64'd0);
        man_valid = 1'b1;
        man_src   = SRC;
        man_data  = 64'h9999;
        @(negedge clk);
        chk("sf_no_rsp_req", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        man_src  = SRC + 8'd1;
        man_data = 64'h5555;
        @(negedge clk);
        chk("sf_req_ready_wait", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        @(negedge clk);
        chk("sf_no_rsp_badsrc", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        man_valid = 1'b1;
        man_src   = SRC;
        man_data  = 64'h1234;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        wait_rsp(lat);
        chk("sf_latency", 64'(lat), 64'd1);
        @(posedge clk);
        #1;
        man_valid = 1'b1;
        man_data  = 64'h4321;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        @(negedge clk);
        chk("idle_d_req_ready", {63'd0, req_ready}, 64'd1);
        repeat (2) @(negedge clk);
        chk("sf_rsp_count", 64'(rsp_cnt - c0), 64'd1);
        slave_auto = 1'b1;

        // Reset while the A beat is still waiting for a_ready
        c0 = rsp_cnt;
        h0 = n_a_hs;
        tb_a_ready = 1'b0;
        issue(2'd0, 3'd0, 3'd3, 1'b0, 64'h3000, 64'd0);
        @(negedge clk);
        chk("abort_a_valid_before", {63'd0, bus.a_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_a_valid", {63'd0, bus.a_valid}, 64'd0);
        chk("abort_d_ready", {63'd0, bus.d_ready}, 64'd0);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tb_a_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_rsp_count", 64'(rsp_cnt - c0), 64'd0);
        chk("abort_a_hs", 64'(n_a_hs - h0), 64'd0);

`ifdef TL_TIMEOUT_EN
        // Watchdog: no D at all, then a stale D, then a normal load
        c0 = rsp_cnt;
        slave_auto = 1'b0;
        man_valid  = 1'b0;
        push_exp(64'd0, 1'b1);
        issue(2'd0, 3'd0, 3'd3, 1'b0, 64'h3000, 64'd0);
        wait_rsp(lat);
        chk("to_latency", 64'(lat), 64'd10);
        @(posedge clk);
        #1;
        man_valid = 1'b1;
        man_src   = SRC;
        man_data  = 64'h7777;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        slave_auto = 1'b1;
        push_exp(64'd15, 1'b0);
        issue(2'd0, 3'd0, 3'd3, 1'b0, 64'h3000, 64'd0);
        wait_rsp(lat);
        chk("to_next_latency", 64'(lat), 64'd3);
        repeat (2) @(negedge clk);
        chk("to_rsp_count", 64'(rsp_cnt - c0), 64'd2);
`endif

        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/tl_master_port.md
# tl_master_port

Single-outstanding TileLink initiator that turns a simple core-side load/store/AMO request into one A-channel beat and returns the D-channel reply. It sits between the core memory stage and the TileLink crossbar, and is the requester counterpart of the RAM slave. The RAM slave takes unaligned data and low-aligned masks, shifts them by the address offset itself, and returns read data already right-aligned. This block therefore sends raw data and returns zero-extended or sign-extended results.

## Interface
- `SOURCE_ID`, default 0: value driven on `a_source`; D responses with any other `d_source` are discarded.
- `TIMEOUT_CYCLES`, default 256: response watchdog limit. Used only with `TL_TIMEOUT_EN`.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: high only in IDLE.
- `req_op` input 2: operation.
  - 0 = load
  - 1 = store
  - 2 = arith AMO
  - 3 = logic AMO
- `req_param` input 3: AMO param, passed to `a_param`. Forced to 0 for load and store.
- `req_size` input 3: log2 of the byte count, 0..3.
- `req_signed` input 1: sign-extend load/AMO result.
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store/AMO operand, low-aligned.
- `rsp_valid` output 1: one-cycle result pulse.
- `rsp_data` output 64: extended result. 0 for stores and errors.
- `rsp_error` output 1: timeout occurred. Qualified by `rsp_valid`.
- `bus` tilelink.master: A and D channels.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - REQ: `a_valid`=1.
  - WAIT: awaiting D.
  - RSP: `rsp_valid`=1.
- IDLE → REQ on `req_valid`: all request fields are registered.
- REQ → WAIT when `a_ready` is sampled high. A fields are held stable until then.
- WAIT → RSP on `d_valid` with `d_source`==`SOURCE_ID`.
- RSP → IDLE unconditionally.
- Opcode mapping:
  - load → `TL_GET`
  - store with size 3 → `TL_PUT_F`
  - store with size < 3 → `TL_PUT_P`
  - op 2 → `TL_ARITH_DATA`
  - op 3 → `TL_LOGIC_DATA`
- `a_mask` is the low-aligned size mask: 8'h01, 8'h03, 8'h0F or 8'hFF for size 0..3.
- `a_data` carries `req_wdata` unshifted. `a_address` carries `req_addr`. `a_size` carries `req_size`. `a_corrupt` is 0.
- Result extension: `d_data` is truncated to 8×2^size bits.
  - `req_signed`=1: sign-extend from the top bit of the truncated field.
  - `req_signed`=0: zero-extend.
  - Size 3: pass through unchanged.
- Stores return `rsp_data`=0, whatever `d_data` carries.
- `d_denied` is ignored.
- `d_ready` is 1 in every state after reset.
  - A `d_valid` outside WAIT is dropped with no state change.
  - A `d_valid` with a mismatched source is dropped.

## Timing
- Reset values:
  - state IDLE
  - `a_valid`=0, `rsp_valid`=0, `rsp_error`=0
  - `rsp_data`=0
  - all A-channel fields 0
  - `d_ready`=0 while `rst_n` is low
- `req_ready` is combinational from state.
- Against a zero-wait slave:
  - request accepted at edge 0
  - `a_valid` high in cycle 1
  - `d_valid` in cycle 2
  - `rsp_valid` in cycle 3
- Minimum request-to-request spacing is 4 cycles.
- `d_valid` arriving in the same cycle as the `a_ready` handshake is not accepted. Only WAIT accepts D.
- Reset mid-transaction:
  - returns to IDLE and drops `a_valid` immediately.
  - No `rsp_valid` is issued for the aborted request.

## Configuration
- Macro `TL_TIMEOUT_EN`, when defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without a matching D: go to RSP with `rsp_error`=1 and `rsp_data`=0.
  - A later stale D is dropped.
- Macro not defined: the counter is absent and WAIT lasts indefinitely. `rsp_error` is tied to 0.

## Test plan
- **Load byte, signed:** addr 0x…05, size 0; slave returns `d_data`=0x80. → `a_opcode`=`TL_GET`, `a_mask`=8'h01; `rsp_data`=0xFFFF_FFFF_FFFF_FF80 in cycle 3.
- **Store, then load word, unsigned:**
  - Store size 2, wdata 0xDEAD_BEEF → `TL_PUT_P`, mask 8'h0F; response has `rsp_data`=0.
  - Load size 2, `req_signed`=0 → `rsp_data`=0x0000_0000_DEAD_BEEF.
- **AMO add:** op 2, param `TL_PARAM_ADD`, size 3, wdata 5; memory holds 10. → `TL_ARITH_DATA`; `rsp_data`=10; a follow-up load returns 15.
- **Backpressure:** `a_ready` held low for 3 cycles. → `a_valid` and all A fields stay stable for those cycles; `req_ready`=0 throughout; one response only.
- **Source filtering:** in WAIT, inject `d_valid` with `d_source`=`SOURCE_ID`+1, then the correct source with 0x1234. → the first is ignored; `rsp_data`=0x1234.
- **Timeout (`TL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** no D response. → `rsp_valid` with `rsp_error`=1 exactly 8 WAIT cycles after entering WAIT; a late D is dropped; the next load completes normally.
